// File: rtl/rf_write_arbiter.sv
// Write-port controller for the register file: round-robin REQ/GNT arbitration of two requesters
// plus a sequenced full-file clear. Optional macro RF_AUTO_CLEAR_EN clears the file after reset.
module rf_write_arbiter #(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 5,
   parameter int NUM_REGS = 32
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              A_REQ,
   input  logic [ADDR_W-1:0] A_ADDR,
   input  logic [DATA_W-1:0] A_DATA,
   output logic              A_GNT,
   input  logic              B_REQ,
   input  logic [ADDR_W-1:0] B_ADDR,
   input  logic [DATA_W-1:0] B_DATA,
   output logic              B_GNT,
   input  logic              CLR_START,
   output logic              BUSY,
   output logic              RF_WR,
   output logic [ADDR_W-1:0] RF_ADRX,
   output logic [DATA_W-1:0] RF_DIN
);

   localparam int CW = $clog2(NUM_REGS + 1);

   typedef enum logic {CLEAR, IDLE} state_t;

`ifdef RF_AUTO_CLEAR_EN
   localparam state_t RST_STATE = CLEAR;
   localparam logic   RST_BUSY  = 1'b1;
`else
   localparam state_t RST_STATE = IDLE;
   localparam logic   RST_BUSY  = 1'b0;
`endif

   state_t            state, state_nx;
   logic [CW-1:0]     cnt, cnt_nx;
   logic              last_b, last_b_nx;
   logic              busy_nx, wr_nx, a_gnt_nx, b_gnt_nx;
   logic [ADDR_W-1:0] adrx_nx;
   logic [DATA_W-1:0] din_nx;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state   <= RST_STATE;
         cnt     <= '0;
         last_b  <= 1'b1;
         BUSY    <= RST_BUSY;
         RF_WR   <= 1'b0;
         RF_ADRX <= '0;
         RF_DIN  <= '0;
         A_GNT   <= 1'b0;
         B_GNT   <= 1'b0;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         last_b  <= last_b_nx;
         BUSY    <= busy_nx;
         RF_WR   <= wr_nx;
         RF_ADRX <= adrx_nx;
         RF_DIN  <= din_nx;
         A_GNT   <= a_gnt_nx;
         B_GNT   <= b_gnt_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      last_b_nx = last_b;
      busy_nx   = BUSY;
      wr_nx     = 1'b0;
      a_gnt_nx  = 1'b0;
      b_gnt_nx  = 1'b0;
      adrx_nx   = RF_ADRX;
      din_nx    = RF_DIN;
      case (state)
         CLEAR: begin
            // Counter reaching NUM_REGS means the last address was already issued last cycle.
            if (cnt == CW'(NUM_REGS)) begin
               state_nx = IDLE;
               busy_nx  = 1'b0;
               cnt_nx   = '0;
            end else begin
               wr_nx   = 1'b1;
               din_nx  = '0;
               adrx_nx = ADDR_W'(cnt);
               cnt_nx  = cnt + CW'(1);
            end
         end
         IDLE: begin
            if (CLR_START) begin
               state_nx = CLEAR;
               busy_nx  = 1'b1;
               cnt_nx   = '0;
            end else if (A_REQ && (!B_REQ || last_b)) begin
               wr_nx     = 1'b1;
               adrx_nx   = A_ADDR;
               din_nx    = A_DATA;
               a_gnt_nx  = 1'b1;
               last_b_nx = 1'b0;
            end else if (B_REQ) begin
               wr_nx     = 1'b1;
               adrx_nx   = B_ADDR;
               din_nx    = B_DATA;
               b_gnt_nx  = 1'b1;
               last_b_nx = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed self-checking bench for rf_write_arbiter with a behavioural REG_FILE write model.
module tb_rf_write_arbiter;

   localparam int DATA_W   = 8;
   localparam int ADDR_W   = 5;
   localparam int NUM_REGS = 32;

`ifdef RF_AUTO_CLEAR_EN
   localparam logic RST_BUSY = 1'b1;
`else
   localparam logic RST_BUSY = 1'b0;
`endif

   logic              CLK = 1'b0;
   logic              RST_N;
   logic              A_REQ, B_REQ, CLR_START;
   logic [ADDR_W-1:0] A_ADDR, B_ADDR;
   logic [DATA_W-1:0] A_DATA, B_DATA;
   logic              A_GNT, B_GNT, BUSY, RF_WR;
   logic [ADDR_W-1:0] RF_ADRX;
   logic [DATA_W-1:0] RF_DIN;

   logic [DATA_W-1:0] mem [NUM_REGS];
   int checks = 0;
   int errors = 0;

   rf_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) dut (
      .CLK(CLK), .RST_N(RST_N),
      .A_REQ(A_REQ), .A_ADDR(A_ADDR), .A_DATA(A_DATA), .A_GNT(A_GNT),
      .B_REQ(B_REQ), .B_ADDR(B_ADDR), .B_DATA(B_DATA), .B_GNT(B_GNT),
      .CLR_START(CLR_START), .BUSY(BUSY),
      .RF_WR(RF_WR), .RF_ADRX(RF_ADRX), .RF_DIN(RF_DIN)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) if (RF_WR) mem[RF_ADRX] <= RF_DIN;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic out_chk(input string tag, input logic wr, input logic [31:0] adrx,
                          input logic [31:0] din, input logic ag, input logic bg, input logic busy);
      check({tag, "_wr"},   RF_WR,   wr);
      check({tag, "_adrx"}, RF_ADRX, adrx);
      check({tag, "_din"},  RF_DIN,  din);
      check({tag, "_agnt"}, A_GNT,   ag);
      check({tag, "_bgnt"}, B_GNT,   bg);
      check({tag, "_busy"}, BUSY,    busy);
   endtask

   // Checks the NUM_REGS zero writes and the closing cycle; optionally pokes CLR_START mid-sequence.
   task automatic run_clear(input bit pulse);
      for (int i = 0; i < NUM_REGS; i++) begin
         if (pulse) CLR_START = (i == 5);
         step();
         out_chk("clr", 1'b1, i, 0, 1'b0, 1'b0, 1'b1);
      end
      CLR_START = 1'b0;
      step();
      out_chk("clr_end", 1'b0, NUM_REGS - 1, 0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic mem_zero_chk(input string tag);
      for (int r = 0; r < NUM_REGS; r++) check(tag, mem[r], 0);
   endtask

   initial begin
      int ia, ib;
      CLR_START = 1'b0;
      A_REQ = 1'b1; A_ADDR = 5'd2; A_DATA = 8'd8;
      B_REQ = 1'b0; B_ADDR = '0;   B_DATA = '0;
      RST_N = 1'b0;
      #2;
      step();
      out_chk("rst", 1'b0, 0, 0, 1'b0, 1'b0, RST_BUSY);
      RST_N = 1'b1;

`ifdef RF_AUTO_CLEAR_EN
      run_clear(1'b0);
      mem_zero_chk("auto_clr_mem");
`endif

      // A_REQ held through reset release
      step();
      out_chk("a_single", 1'b1, 2, 8'd8, 1'b1, 1'b0, 1'b0);
      A_REQ = 1'b0;
      step();
      out_chk("idle_hold", 1'b0, 2, 8'd8, 1'b0, 1'b0, 1'b0);
      check("mem2", mem[2], 8'd8);

      B_REQ = 1'b1; B_ADDR = 5'd5; B_DATA = 8'h55;
      step();
      out_chk("b_single", 1'b1, 5, 8'h55, 1'b0, 1'b1, 1'b0);
      B_REQ = 1'b0;

      // Contention: A writes i to reg i, B writes 31-i to reg 31-i
      ia = 0; ib = 0;
      A_REQ = 1'b1; A_ADDR = 5'd0;  A_DATA = 8'd0;
      B_REQ = 1'b1; B_ADDR = 5'd31; B_DATA = 8'd31;
      for (int k = 0; k < 32; k++) begin
         step();
         if (k % 2 == 0) out_chk("rr_a", 1'b1, k / 2, k / 2, 1'b1, 1'b0, 1'b0);
         else            out_chk("rr_b", 1'b1, 31 - k / 2, 31 - k / 2, 1'b0, 1'b1, 1'b0);
         if (A_GNT) begin
            ia++;
            if (ia == 16) A_REQ = 1'b0;
            else begin A_ADDR = 5'(ia); A_DATA = 8'(ia); end
         end
         if (B_GNT) begin
            ib++;
            if (ib == 16) B_REQ = 1'b0;
            else begin B_ADDR = 5'(31 - ib); B_DATA = 8'(31 - ib); end
         end
      end
      step();
      out_chk("rr_done", 1'b0, 16, 16, 1'b0, 1'b0, 1'b0);
      for (int r = 0; r < NUM_REGS; r++) check("rr_mem", mem[r], r);

      // Clear beats a simultaneous request; CLR_START mid-clear must not restart it
      CLR_START = 1'b1;
      B_REQ = 1'b1; B_ADDR = 5'd7; B_DATA = 8'h77;
      step();
      out_chk("clr_req", 1'b0, 16, 16, 1'b0, 1'b0, 1'b1);
      CLR_START = 1'b0;
      run_clear(1'b1);
      mem_zero_chk("clr_mem");
      step();
      out_chk("b_after_clr", 1'b1, 7, 8'h77, 1'b0, 1'b1, 1'b0);
      B_REQ = 1'b0;
      step();
      check("mem7", mem[7], 8'h77);

      // Reset in the middle of a clear sequence
      CLR_START = 1'b1;
      step();
      CLR_START = 1'b0;
      for (int i = 0; i < 18; i++) step();
      check("mid_adrx", RF_ADRX, 17);
      RST_N = 1'b0;
      #1;
      out_chk("rst_mid", 1'b0, 0, 0, 1'b0, 1'b0, RST_BUSY);
      step();
      RST_N = 1'b1;
`ifdef RF_AUTO_CLEAR_EN
      run_clear(1'b0);
`else
      step();
      out_chk("post_rst_idle", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
`endif

      // Reset returns the round-robin pointer so A wins the first tie
      A_REQ = 1'b1; A_ADDR = 5'd1; A_DATA = 8'h11;
      B_REQ = 1'b1; B_ADDR = 5'd3; B_DATA = 8'h33;
      step();
      out_chk("ptr_a", 1'b1, 1, 8'h11, 1'b1, 1'b0, 1'b0);
      A_REQ = 1'b0;
      step();
      out_chk("ptr_b", 1'b1, 3, 8'h33, 1'b0, 1'b1, 1'b0);
      B_REQ = 1'b0;
      step();
      out_chk("end", 1'b0, 3, 8'h33, 1'b0, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
